// File: rtl/i2c_byte_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2c_byte_ctrl
// Description : I2C master byte engine. Each divider tick advances one
//               quarter-bit phase; sequences optional START, 8 data bits,
//               ACK slot and optional STOP on open-drain SCL/SDA enables.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_byte_ctrl (
    input  logic       clk,
    input  logic       rst,        // asynchronous, active low
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic [7:0] tx_data,
    input  logic       ack_in,
    input  logic       sda_i,
    output logic [7:0] rx_data,
    output logic       ack_out,
    output logic       done,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_START = 3'd1;
    localparam logic [2:0] C_ST_DATA  = 3'd2;
    localparam logic [2:0] C_ST_ACK   = 3'd3;
    localparam logic [2:0] C_ST_STOP  = 3'd4;
    localparam logic [2:0] C_ST_DONE  = 3'd5;

    localparam logic [1:0] C_PH0 = 2'd0;
    localparam logic [1:0] C_PH1 = 2'd1;
    localparam logic [1:0] C_PH2 = 2'd2;
    localparam logic [1:0] C_PH3 = 2'd3;

    logic [2:0] state_q,     state_d;
    logic [1:0] phase_q,     phase_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic       bus_owned_q, bus_owned_d;
    logic       scl_oe_q,    scl_oe_d;
    logic       sda_oe_q,    sda_oe_d;
    logic [7:0] rx_shift_q,  rx_shift_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       ack_out_q,   ack_out_d;
    logic       cmd_stop_q,  cmd_stop_d;
    logic       cmd_read_q,  cmd_read_d;
    logic [7:0] tx_data_q,   tx_data_d;
    logic       ack_in_q,    ack_in_d;

    logic       accept;

    assign accept    = cmd_valid && (state_q == C_ST_IDLE);
    assign cmd_ready = (state_q == C_ST_IDLE);
    assign busy      = (state_q != C_ST_IDLE);
    assign done      = (state_q == C_ST_DONE);
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;
    assign rx_data   = rx_data_q;
    assign ack_out   = ack_out_q;

    // State register and all datapath flops; reset releases both lines at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= C_ST_IDLE;
            phase_q     <= C_PH0;
            bit_cnt_q   <= 3'd0;
            bus_owned_q <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_shift_q  <= 8'h00;
            rx_data_q   <= 8'h00;
            ack_out_q   <= 1'b0;
            cmd_stop_q  <= 1'b0;
            cmd_read_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            ack_in_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            bus_owned_q <= bus_owned_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            ack_out_q   <= ack_out_d;
            cmd_stop_q  <= cmd_stop_d;
            cmd_read_q  <= cmd_read_d;
            tx_data_q   <= tx_data_d;
            ack_in_q    <= ack_in_d;
        end
    end

    // Next-state: phase/bit sequencing, advancing only on tick in bus states
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            C_ST_IDLE: begin
                // a tick coinciding with accept is deliberately not consumed
                if (accept) begin
                    state_d   = cmd_start ? C_ST_START : C_ST_DATA;
                    phase_d   = C_PH0;
                    bit_cnt_d = 3'd7;
                end
            end
            C_ST_START: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == C_PH3) begin
                        state_d = C_ST_DATA;
                    end
                end
            end
            C_ST_DATA: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == C_PH3) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d = C_ST_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
            end
            C_ST_ACK: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == C_PH3) begin
                        state_d = cmd_stop_q ? C_ST_STOP : C_ST_DONE;
                    end
                end
            end
            C_ST_STOP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == C_PH3) begin
                        state_d = C_ST_DONE;
                    end
                end
            end
            C_ST_DONE: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
                phase_d = C_PH0;
            end
        endcase
    end

    // Outputs: line enables per phase, command latch, rx/ack capture
    always_comb begin
        bus_owned_d = bus_owned_q;
        scl_oe_d    = scl_oe_q;
        sda_oe_d    = sda_oe_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        ack_out_d   = ack_out_q;
        cmd_stop_d  = cmd_stop_q;
        cmd_read_d  = cmd_read_q;
        tx_data_d   = tx_data_q;
        ack_in_d    = ack_in_q;
        case (state_q)
            C_ST_IDLE: begin
                // SCL stays low between bytes of an open transaction
                scl_oe_d = bus_owned_q;
                sda_oe_d = 1'b0;
                if (accept) begin
                    cmd_stop_d = cmd_stop;
                    cmd_read_d = cmd_read;
                    tx_data_d  = tx_data;
                    ack_in_d   = ack_in;
                end
            end
            C_ST_START: begin
                if (tick) begin
                    case (phase_q)
                        C_PH0: begin
                            // on a repeated START SCL is still low while SDA releases
                            scl_oe_d = bus_owned_q;
                            sda_oe_d = 1'b0;
                        end
                        C_PH1: begin
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        C_PH2: begin
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b1;
                        end
                        default: begin
                            scl_oe_d    = 1'b1;
                            sda_oe_d    = 1'b1;
                            bus_owned_d = 1'b1;
                        end
                    endcase
                end
            end
            C_ST_DATA: begin
                if (tick) begin
                    case (phase_q)
                        C_PH0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = cmd_read_q ? 1'b0 : ~tx_data_q[bit_cnt_q];
                        end
                        C_PH1: begin
                            scl_oe_d = 1'b0;
                        end
                        C_PH2: begin
                            scl_oe_d = 1'b0;
                            if (cmd_read_q) begin
                                rx_shift_d = {rx_shift_q[6:0], sda_i};
                            end
                        end
                        default: begin
                            scl_oe_d = 1'b1;
                        end
                    endcase
                end
            end
            C_ST_ACK: begin
                if (tick) begin
                    case (phase_q)
                        C_PH0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = cmd_read_q ? ~ack_in_q : 1'b0;
                        end
                        C_PH1: begin
                            scl_oe_d = 1'b0;
                        end
                        C_PH2: begin
                            scl_oe_d = 1'b0;
                            if (!cmd_read_q) begin
                                ack_out_d = sda_i;
                            end
                        end
                        default: begin
                            scl_oe_d = 1'b1;
                        end
                    endcase
                end
            end
            C_ST_STOP: begin
                if (tick) begin
                    case (phase_q)
                        C_PH0: begin
                            scl_oe_d = 1'b1;
                            sda_oe_d = 1'b1;
                        end
                        C_PH1: begin
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b1;
                        end
                        C_PH2: begin
                            scl_oe_d = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                        default: begin
                            scl_oe_d    = 1'b0;
                            sda_oe_d    = 1'b0;
                            bus_owned_d = 1'b0;
                        end
                    endcase
                end
            end
            C_ST_DONE: begin
                // pre-load idle levels so IDLE shows them from its first cycle
                scl_oe_d = bus_owned_q;
                sda_oe_d = 1'b0;
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
        // received byte becomes visible together with done
        if ((state_d == C_ST_DONE) && (state_q != C_ST_DONE) && cmd_read_q) begin
            rx_data_d = rx_shift_q;
        end
    end

endmodule
`default_nettype wire

// File: doc/i2c_byte_ctrl.md
Name: i2c_byte_ctrl

Overview:
- I2C master byte engine, directly downstream of the clock divider.
- Consumes the divider's single-cycle `tick` strobe and sequences START, 8 data bits, ACK and STOP on open-drain SCL/SDA.
- Each tick advances one quarter-bit phase, so SCL period = 4 ticks.
- Accepts one byte command at a time from the transaction controller over a valid/ready handshake.

Parameters:
- None. Bus timing is set entirely by the tick rate from the divider.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- tick  input  1  one-cycle quarter-bit strobe from divider
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
- cmd_start  input  1  issue START (or repeated START) before the byte
- cmd_stop  input  1  issue STOP after the ACK slot
- cmd_read  input  1  1 = read byte, 0 = write byte
- tx_data  input  8  write byte, MSB first
- ack_in  input  1  ACK bit master sends on a read (0 = ACK, 1 = NACK)
- sda_i  input  1  sampled SDA line
- rx_data  output  8  received byte
- ack_out  output  1  ACK bit sampled from slave on a write
- done  output  1  one-cycle completion pulse
- busy  output  1  state != IDLE
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset (async, rst=0):
  - State=IDLE; phase, bit counter and bus_owned cleared.
  - Outputs: scl_oe=0, sda_oe=0, done=0, busy=0, rx_data=0, ack_out=0; cmd_ready=1 after release.
  - Reset mid-transfer releases both lines immediately; no STOP is generated.
- Accept:
  - In IDLE, cmd_valid && cmd_ready latches cmd_start, cmd_stop, cmd_read, tx_data and ack_in.
  - Next state is START if cmd_start=1, else DATA.
  - A tick in the accept cycle is ignored; the first phase executes on the next tick.
- Command legality: a command with cmd_start=0 while bus_owned=0 is still executed; the bus-error case is the caller's responsibility.
- Phase timing:
  - States other than IDLE/DONE advance only on tick.
  - 2-bit phase counter 0..3; outputs registered and updated on the tick cycle.
- START phases:
  - ph0: scl_oe=bus_owned, sda_oe=0
  - ph1: scl_oe=0, sda_oe=0
  - ph2: scl_oe=0, sda_oe=1
  - ph3: scl_oe=1, sda_oe=1
  - Sets bus_owned=1. Valid from idle or as a repeated START.
- DATA, bits 7 down to 0, 3-bit counter:
  - ph0: scl_oe=1; sda_oe = write ? ~tx_bit : 0
  - ph1: scl_oe=0
  - ph2: scl_oe=0; sample sda_i into rx shift register (read only)
  - ph3: scl_oe=1
  - After bit0 ph3 the next state is ACK.
- ACK:
  - Same four phases as DATA.
  - Write: SDA released; ph2 samples sda_i into ack_out.
  - Read: sda_oe = ~ack_in; ack_out unchanged.
  - After ph3 the next state is STOP if cmd_stop=1, else DONE.
- STOP phases:
  - ph0: scl_oe=1, sda_oe=1
  - ph1: scl_oe=0, sda_oe=1
  - ph2: scl_oe=0, sda_oe=0
  - ph3: scl_oe=0, sda_oe=0
  - Clears bus_owned.
- DONE:
  - One cycle, no tick needed; done=1 and rx_data updated (read) in this cycle.
  - Returns to IDLE.
- IDLE line levels:
  - scl_oe=bus_owned, so SCL is held low between bytes of an open transaction.
  - sda_oe=0.
- Latency in ticks from accept to done: START +4, DATA 32, ACK 4, STOP +4. Full START+byte+STOP = 44 ticks, then done 1 clk later.
- Back-to-back: the next command may be accepted the cycle after done.
- Command inputs are ignored while busy.

Test Plan:
- Reset with busy mid-byte: assert rst=0 during DATA bit 3 -> scl_oe=0, sda_oe=0, busy=0 in the same cycle; cmd_ready=1 after release.
- Write 0xA5, start+stop, tick every 5 clk, slave pulls sda_i=0 in ACK ph2:
  - SDA levels at SCL rising edges = 1,0,1,0,0,1,0,1.
  - done 1 clk after the 44th tick, ack_out=0.
  - Lines released; bus_owned=0.
- Read, cmd_start=0/cmd_stop=1 after prior write, slave drives 0x3C, ack_in=1 -> rx_data=0x3C at done, sda_oe=0 during ACK, STOP sequence follows.
- Write without stop, then repeated start:
  - SCL held low (scl_oe=1) in IDLE between commands.
  - Second command with cmd_start=1 releases SDA in ph0, SCL in ph1, pulls SDA low in ph2 while SCL released.
- Write with sda_i=1 in ACK -> ack_out=1 at done.
- tick asserted in the same cycle as accept -> ignored; exactly 36 further ticks (no start/stop) to done.
- cmd_valid toggled while busy -> no effect; tx_data changes mid-byte do not alter the SDA pattern.
